uart_rx_baud: RTL and testbench

- Asynchronous serial receiver with an integrated baud-tick generator.
- A free-running mod-M counter produces a 16x-oversampling tick. The receive FSM uses it to sample 8N1 frames on `rx`, LSB first.
- Each good byte is presented on `rx_dout` with a one-cycle `rx_fifo_wr` strobe, for the downstream RX FIFO in the UART datapath.

---
 rtl/uart_rx_baud.sv | 130 +++++++++++++
 tb/tb_uart_rx_baud.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_baud.sv
`timescale 1ns/1ps
// uart_rx_baud: 8N1 serial receiver with a free-running 16x baud-tick generator.
// Optional macro UART_RX_SYNC_EN inserts a 2-flop synchronizer on rx.
module uart_rx_baud #(
    parameter int M       = 27,
    parameter int N       = 5,
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx,
    output logic            s_tick,
    output logic            rx_fifo_wr,
    output logic            rx_busy,
    output logic [DBIT-1:0] rx_dout
);
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_reg, state_next;
    logic [N-1:0]    q_reg, q_next;
    logic [SW-1:0]   s_reg, s_next;
    logic [NW-1:0]   n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic [DBIT-1:0] dout_reg, dout_next;
    logic            wr_reg, wr_next;
    logic            rx_s;

`ifdef UART_RX_SYNC_EN
    // Both stages reset to the idle line level so reset never looks like a start bit.
    logic [1:0] sync_reg;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_reg <= 2'b11;
        else        sync_reg <= {sync_reg[0], rx};
    end
    assign rx_s = sync_reg[1];
`else
    assign rx_s = rx;
`endif

    assign s_tick = (q_reg == N'(M - 1));
    assign q_next = s_tick ? '0 : q_reg + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_reg     <= '0;
            state_reg <= IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            dout_reg  <= '0;
            wr_reg    <= 1'b0;
        end else begin
            q_reg     <= q_next;
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            dout_reg  <= dout_next;
            wr_reg    <= wr_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        s_next     = s_reg;
        n_next     = n_reg;
        b_next     = b_reg;
        dout_next  = dout_reg;
        wr_next    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rx_s) begin
                    state_next = START;
                    s_next     = '0;
                end
            end
            START: begin
                // Eighth tick lands mid start bit; a high line here was only a glitch.
                if (s_tick) begin
                    if (s_reg == SW'(7)) begin
                        if (!rx_s) begin
                            state_next = DATA;
                            s_next     = '0;
                            n_next     = '0;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == SW'(15)) begin
                        s_next = '0;
                        b_next = {rx_s, b_reg[DBIT-1:1]};
                        if (n_reg == NW'(DBIT - 1)) state_next = STOP;
                        else                        n_next = n_reg + 1'b1;
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_reg == SW'(SB_TICK - 1)) begin
                        state_next = IDLE;
                        if (rx_s) begin
                            dout_next = b_reg;
                            wr_next   = 1'b1;
                        end
                    end else begin
                        s_next = s_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rx_busy    = (state_reg != IDLE);
    assign rx_fifo_wr = wr_reg;
    assign rx_dout    = dout_reg;

endmodule

// File: tb/tb_uart_rx_baud.sv
`timescale 1ns/1ps
// Randomized self-checking bench for uart_rx_baud: frames are decoded by a
// frame-level model (good stop -> one byte, bad stop or glitch -> nothing).
module tb_uart_rx_baud;
    localparam int M        = 27;
    localparam int BIT_CLKS = 16 * M;
    localparam longint LAT_LO = 4079;
    localparam longint LAT_HI = 4107;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       s_tick, rx_fifo_wr, rx_busy;
    logic [7:0] rx_dout;

    uart_rx_baud #(.M(M), .N(5), .DBIT(8), .SB_TICK(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .s_tick    (s_tick),
        .rx_fifo_wr(rx_fifo_wr),
        .rx_busy   (rx_busy),
        .rx_dout   (rx_dout)
    );

    always #1 clk = ~clk;

    int         errors = 0;
    int         checks = 0;
    longint     cyc = 0;
    logic [7:0] got_q[$];
    longint     got_cyc[$];
    logic       wr_prev = 1'b0;
    int         double_wr = 0;
    logic [7:0] model_dout = 8'h00;
    int         exp_total = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_fifo_wr) begin
            got_q.push_back(rx_dout);
            got_cyc.push_back(cyc);
            if (wr_prev) double_wr++;
        end
        wr_prev = rx_fifo_wr;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: observed=0x%0h required=0x%0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_frame(input logic [7:0] data, input bit stop_ok, input bit tight,
                            input int gap, input string name);
        int     n0;
        longint t0;
        int     k;
        longint lat;
        n0 = got_q.size();
        t0 = cyc;
        rx = 1'b0;
        repeat (100) @(negedge clk);
        check_val({name, "_busy_start"}, rx_busy, 1);
        repeat (BIT_CLKS - 100) @(negedge clk);
        for (int i = 0; i < 8; i++) hold(data[i], BIT_CLKS);
        if (!stop_ok) begin
            hold(1'b0, BIT_CLKS * 3 / 4);
            hold(1'b1, gap);
        end else if (tight) begin
            rx = 1'b1;
            k = 0;
            while (!rx_fifo_wr && k < BIT_CLKS) begin
                @(negedge clk);
                k++;
            end
            check_val({name, "_strobe_seen"}, rx_fifo_wr, 1);
        end else begin
            hold(1'b1, BIT_CLKS + gap);
        end
        #0.1;
        if (stop_ok) begin
            model_dout = data;
            exp_total++;
        end
        check_val({name, "_strobes"}, got_q.size() - n0, stop_ok ? 1 : 0);
        if (stop_ok && got_q.size() > n0) begin
            check_val({name, "_byte"}, got_q[n0], data);
            lat = got_cyc[n0] - t0;
            check_val({name, "_latency_ok"}, (lat >= LAT_LO && lat <= LAT_HI), 1);
        end
        check_val({name, "_dout"}, rx_dout, model_dout);
        if (!tight) check_val({name, "_busy_idle"}, rx_busy, 0);
        $display("frame %s data=0x%02h stop_ok=%0d tight=%0d strobes=%0d dout=0x%02h",
                 name, data, stop_ok, tight, got_q.size() - n0, rx_dout);
    endtask

    task automatic do_glitch(input int len, input string name);
        int n0;
        n0 = got_q.size();
        rx = 1'b0;
        repeat (len / 2) @(negedge clk);
        check_val({name, "_busy"}, rx_busy, 1);
        repeat (len - len / 2) @(negedge clk);
        hold(1'b1, 300);
        #0.1;
        check_val({name, "_strobes"}, got_q.size() - n0, 0);
        check_val({name, "_dout"}, rx_dout, model_dout);
        check_val({name, "_busy_idle"}, rx_busy, 0);
        $display("glitch %s len=%0d clks dout=0x%02h", name, len, rx_dout);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        longint     c_rel, t1;
        int         k, n0;
        logic [7:0] abyte;
        logic [7:0] d;
        bit         ok, tt;

        #0.5 reset = 1'b0;
        #0.2;
        check_val("reset_s_tick", s_tick, 0);
        check_val("reset_busy", rx_busy, 0);
        check_val("reset_wr", rx_fifo_wr, 0);
        check_val("reset_dout", rx_dout, 8'h00);
        #1.8 reset = 1'b1;
        c_rel = cyc;

        // Tick generator: first tick M-1 clocks after release, then every M clocks.
        k = 0;
        @(negedge clk);
        while (!s_tick && k < 2 * M) begin
            @(negedge clk);
            k++;
        end
        check_val("first_tick_delay", cyc - c_rel, M - 1);
        for (int p = 0; p < 3; p++) begin
            t1 = cyc;
            @(negedge clk);
            check_val("tick_width", s_tick, 0);
            k = 0;
            while (!s_tick && k < 2 * M) begin
                @(negedge clk);
                k++;
            end
            check_val("tick_period", cyc - t1, M);
            $display("tick period measured=%0d clks", cyc - t1);
        end

        n0 = got_q.size();
        hold(1'b1, 1000);
        check_val("idle_strobes", got_q.size() - n0, 0);
        check_val("idle_busy", rx_busy, 0);
        check_val("idle_dout", rx_dout, 8'h00);

        do_frame(8'hAB, 1, 0, 450, "ab");
        do_frame(8'hAC, 1, 0, 450, "ac");
        do_glitch(50, "glitch");
        do_frame(8'h55, 0, 0, 450, "framing");

        // Reset asserted in the middle of the data bits.
        abyte = 8'hAB;
        n0 = got_q.size();
        rx = 1'b0;
        repeat (BIT_CLKS) @(negedge clk);
        for (int i = 0; i < 3; i++) hold(abyte[i], BIT_CLKS);
        check_val("midreset_busy_before", rx_busy, 1);
        #0.5 reset = 1'b0;
        #0.2;
        check_val("midreset_busy", rx_busy, 0);
        check_val("midreset_dout", rx_dout, 8'h00);
        check_val("midreset_wr", rx_fifo_wr, 0);
        @(negedge clk);
        reset = 1'b1;
        model_dout = 8'h00;
        hold(1'b1, BIT_CLKS);
        check_val("midreset_strobes", got_q.size() - n0, 0);
        $display("reset mid-frame dout=0x%02h busy=%0d", rx_dout, rx_busy);
        do_frame(8'h3C, 1, 0, 450, "after_reset");

        // Next start edge one clock after the return to IDLE.
        do_frame(8'h5A, 1, 1, 0, "tight");
        do_frame(8'hC3, 1, 0, 300, "after_tight");

        for (int r = 0; r < 6; r++) begin
            if ($urandom_range(0, 3) == 0) do_glitch($urandom_range(10, 150), "rnd_glitch");
            d  = 8'($urandom);
            ok = ($urandom_range(0, 3) != 0);
            tt = ok && (r < 5) && ($urandom_range(0, 2) == 0);
            do_frame(d, ok, tt, $urandom_range(BIT_CLKS / 2, BIT_CLKS), "rnd");
        end

        hold(1'b1, 500);
        #0.1;
        check_val("strobe_single_cycle", double_wr, 0);
        check_val("total_strobes", got_q.size(), exp_total);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
